// File: rtl/byte_serializer_tx.sv
// byte_serializer_tx: valid/ready word in, LSB-first start/data/stop frame out, each bit held BIT_CYCLES clocks.
// Define BYTE_SERIALIZER_TX_PARITY_EN to insert an even-parity bit between data and stop.
module byte_serializer_tx #(
   parameter int DATA_W     = 8,
   parameter int BIT_CYCLES = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx_line,
   output logic              busy,
   output logic              tx_done
);
   localparam int CW = $clog2(BIT_CYCLES + 1);
   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t            state;
   logic [DATA_W-1:0] sr;
   logic [DATA_W-1:0] sr_nx;
   logic [BW-1:0]     bit_cnt;
   logic [CW-1:0]     cyc_cnt;
   logic              bit_end;
`ifdef BYTE_SERIALIZER_TX_PARITY_EN
   logic              parity;
`endif
   assign bit_end = cyc_cnt == CYC_LAST;
   assign sr_nx   = sr >> 1;
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state    <= IDLE;
         sr       <= '0;
         bit_cnt  <= '0;
         cyc_cnt  <= '0;
         tx_line  <= 1'b1;
         in_ready <= 1'b1;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
`ifdef BYTE_SERIALIZER_TX_PARITY_EN
         parity   <= 1'b0;
`endif
      end else begin
         tx_done <= 1'b0;
         cyc_cnt <= (state == IDLE || bit_end) ? '0 : cyc_cnt + 1'b1;
         case (state)
            IDLE: if (in_valid) begin
               state    <= START;
               sr       <= in_data;
               bit_cnt  <= '0;
               tx_line  <= 1'b0;
               in_ready <= 1'b0;
               busy     <= 1'b1;
`ifdef BYTE_SERIALIZER_TX_PARITY_EN
               parity   <= ^in_data;
`endif
            end
            START: if (bit_end) begin
               state   <= DATA;
               tx_line <= sr[0];
            end
            DATA: if (bit_end) begin
               if (bit_cnt == BIT_LAST) begin
`ifdef BYTE_SERIALIZER_TX_PARITY_EN
                  state   <= PARITY;
                  tx_line <= parity;
`else
                  state   <= STOP;
                  tx_line <= 1'b1;
`endif
               end else begin
                  sr      <= sr_nx;
                  tx_line <= sr_nx[0];
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            PARITY: if (bit_end) begin
               state   <= STOP;
               tx_line <= 1'b1;
            end
            STOP: if (bit_end) begin
               state    <= IDLE;
               in_ready <= 1'b1;
               busy     <= 1'b0;
               tx_done  <= 1'b1;
            end
            default: begin
               state    <= IDLE;
               tx_line  <= 1'b1;
               in_ready <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
   end
endmodule
